ex_hazard_scheduler: RTL and testbench
======================================

EX_HAZARD_SCHEDULER -- requirements
Module: ex_hazard_scheduler

Interface
REQ-001 Parameter: MUL_CYCLES, 4, total EX-stage cycles of a multi-cycle op; legal range 2..16.
REQ-002 clock  in  1  single clock; all state updates on rising edge.
REQ-003 resetn  in  1  synchronous active-low reset, sampled on rising edge of clock.
REQ-004 IFIDRs, IFIDRt  in  5 each  source registers of the instruction in ID.
REQ-005 IDEXRs, IDEXRt  in  5 each  source registers of the instruction in EX.
REQ-006 IDEXMemRead  in  1  instruction in EX is a load; its destination is IDEXRt.
REQ-007 IDEXMulStart  in  1  instruction in EX is a multi-cycle op (mult/div).
REQ-008 EXMEMRegWrite, MEMWBRegWrite  in  1 each  write-back enables of the later stages.
REQ-009 EXMEMDst, MEMWBDst  in  5 each  destination registers of the later stages.
REQ-010 ForwardA, ForwardB  out  2 each  EX operand select: 00 register file, 10 MEMForwarding, 01 WBForwarding.
REQ-011 PCWrite, IFIDWrite, IDEXWrite  out  1 each  pipeline register enables; 1 = update.
REQ-012 IDEXFlush  out  1  insert bubble into ID/EX (zero control bits).
REQ-013 EXMEMBubble  out  1  insert bubble into EX/MEM.
REQ-014 MulDone  out  1  one-cycle pulse: multi-cycle result valid this cycle.
REQ-015 Busy  out  1  1 while the state machine is in BUSY.
REQ-016 StallCount  out  16  count of cycles with PCWrite=0.

Function
REQ-017 ForwardA SHALL be 10 when EXMEMRegWrite=1, EXMEMDst!=0 and EXMEMDst==IDEXRs; else 01 when MEMWBRegWrite=1, MEMWBDst!=0 and MEMWBDst==IDEXRs; else 00.
REQ-018 ForwardB SHALL follow REQ-017 with IDEXRt in place of IDEXRs; MEM match SHALL win over WB match.
REQ-019 Forwarding outputs SHALL be combinational, independent of FSM state.
REQ-020 FSM SHALL have two states: IDLE, BUSY; plus a 4-bit down-counter Cnt.
REQ-021 IDLE, IDEXMulStart=1: Hold active this cycle, Cnt <= MUL_CYCLES-2, next state BUSY.
REQ-022 BUSY, Cnt!=0: Hold active, Cnt <= Cnt-1, stay BUSY.
REQ-023 BUSY, Cnt==0: Hold inactive, MulDone=1, next state IDLE; IDEXMulStart ignored this cycle.
REQ-024 Net latency: MulStart sampled in IDLE at cycle t -> Hold in cycles t..t+MUL_CYCLES-2, MulDone at t+MUL_CYCLES-1.
REQ-025 Hold active: PCWrite=0, IFIDWrite=0, IDEXWrite=0, EXMEMBubble=1, IDEXFlush=0.
REQ-026 Load-use: IDEXMemRead=1, IDEXRt!=0 and (IDEXRt==IFIDRs or IDEXRt==IFIDRt) -> PCWrite=0, IFIDWrite=0, IDEXFlush=1, IDEXWrite=1, EXMEMBubble=0.
REQ-027 Hold SHALL take priority over load-use; load-use SHALL be suppressed in any Hold cycle.
REQ-028 No Hold and no load-use: PCWrite=IFIDWrite=IDEXWrite=1, IDEXFlush=EXMEMBubble=0.
REQ-029 IDEXMemRead=1 and IDEXMulStart=1 together: treat as multi-cycle op only.
REQ-030 StallCount SHALL increment on each rising edge where PCWrite=0, saturating at 16'hFFFF.
REQ-031 Busy SHALL equal (state==BUSY); MulDone SHALL be 0 outside REQ-023.

Reset
REQ-032 resetn=0 at a rising edge: state <= IDLE, Cnt <= 0, StallCount <= 0.
REQ-033 Reset mid-BUSY SHALL abort the op with no MulDone pulse.
REQ-034 Reset SHALL take priority over IDEXMulStart sampled the same edge.
REQ-035 Following reset, outputs SHALL be combinational from IDLE: with idle inputs PCWrite=IFIDWrite=IDEXWrite=1, others 0.

Verification
REQ-036 IDEXRs=4, EXMEMRegWrite=1, EXMEMDst=4, MEMWBRegWrite=1, MEMWBDst=4 -> ForwardA=10; then EXMEMDst=0 -> ForwardA=01; MEMWBRegWrite=0 -> 00.
REQ-037 IDEXMemRead=1, IDEXRt=8, IFIDRt=8 for one cycle -> PCWrite=0, IFIDWrite=0, IDEXFlush=1 that cycle; StallCount 0->1.
REQ-038 MUL_CYCLES=4, IDEXMulStart=1 at cycle 0 and held -> Hold cycles 0,1,2; Busy=1 cycles 1,2,3; MulDone=1 only cycle 3; IDLE cycle 4, which restarts if MulStart still 1.
REQ-039 MulStart and load-use match asserted together -> EXMEMBubble=1, IDEXFlush=0 for cycles 0..2.
REQ-040 resetn=0 at cycle 2 of a MUL_CYCLES=4 op -> Busy=0, MulDone never pulses, StallCount=0 next cycle.
REQ-041 Force 70000 load-use cycles -> StallCount=16'hFFFF, no wrap.

Source files
------------

// File: rtl/ex_hazard_scheduler_if.sv
// Pipeline hazard bus between the datapath and the EX hazard scheduler.
// The master side is the pipeline datapath and the slave side is the scheduler.
interface ex_hazard_scheduler_if;
  logic [4:0]  IFIDRs;
  logic [4:0]  IFIDRt;
  logic [4:0]  IDEXRs;
  logic [4:0]  IDEXRt;
  logic        IDEXMemRead;
  logic        IDEXMulStart;
  logic        EXMEMRegWrite;
  logic        MEMWBRegWrite;
  logic [4:0]  EXMEMDst;
  logic [4:0]  MEMWBDst;
  logic [1:0]  ForwardA;
  logic [1:0]  ForwardB;
  logic        PCWrite;
  logic        IFIDWrite;
  logic        IDEXWrite;
  logic        IDEXFlush;
  logic        EXMEMBubble;
  logic        MulDone;
  logic        Busy;
  logic [15:0] StallCount;

  modport master (
    output IFIDRs, IFIDRt, IDEXRs, IDEXRt, IDEXMemRead, IDEXMulStart,
           EXMEMRegWrite, MEMWBRegWrite, EXMEMDst, MEMWBDst,
    input  ForwardA, ForwardB, PCWrite, IFIDWrite, IDEXWrite, IDEXFlush,
           EXMEMBubble, MulDone, Busy, StallCount
  );

  modport slave (
    input  IFIDRs, IFIDRt, IDEXRs, IDEXRt, IDEXMemRead, IDEXMulStart,
           EXMEMRegWrite, MEMWBRegWrite, EXMEMDst, MEMWBDst,
    output ForwardA, ForwardB, PCWrite, IFIDWrite, IDEXWrite, IDEXFlush,
           EXMEMBubble, MulDone, Busy, StallCount
  );
endinterface

// File: rtl/ex_hazard_scheduler.sv
// EX-stage hazard unit: operand forwarding, load-use stall, and a multi-cycle
// op sequencer that freezes the front of the pipe while mult/div runs.
module ex_hazard_scheduler #(
  parameter int MUL_CYCLES = 4
) (
  input logic            clock,
  input logic            resetn,
  ex_hazard_scheduler_if.slave hz
);
  localparam logic [3:0] CNT_INIT = 4'(MUL_CYCLES - 2);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [15:0] stallCount;
  logic        hold;
  logic        mulDone;
  logic        loadUse;

  function automatic logic [1:0] fwdSelect(input logic [4:0] src);
    if (hz.EXMEMRegWrite && hz.EXMEMDst != 5'd0 && hz.EXMEMDst == src)
      return 2'b10;
    else if (hz.MEMWBRegWrite && hz.MEMWBDst != 5'd0 && hz.MEMWBDst == src)
      return 2'b01;
    else
      return 2'b00;
  endfunction

  assign hz.ForwardA = fwdSelect(hz.IDEXRs);
  assign hz.ForwardB = fwdSelect(hz.IDEXRt);

  always_comb begin
    hold    = 1'b0;
    mulDone = 1'b0;
    unique case (state)
      IDLE: hold = hz.IDEXMulStart;
      BUSY: begin
        hold    = (cnt != 4'd0);
        mulDone = (cnt == 4'd0);
      end
      default: hold = 1'b0;
    endcase
  end

  // A load flagged together with MulStart is handled purely as a multi-cycle op.
  assign loadUse = !hold && hz.IDEXMemRead && !hz.IDEXMulStart && hz.IDEXRt != 5'd0 &&
                   (hz.IDEXRt == hz.IFIDRs || hz.IDEXRt == hz.IFIDRt);

  assign hz.PCWrite     = !(hold || loadUse);
  assign hz.IFIDWrite   = !(hold || loadUse);
  assign hz.IDEXWrite   = !hold;
  assign hz.IDEXFlush   = loadUse;
  assign hz.EXMEMBubble = hold;
  assign hz.MulDone     = mulDone;
  assign hz.Busy        = (state == BUSY);
  assign hz.StallCount  = stallCount;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      stallCount <= 16'd0;
    end else begin
      if (!hz.PCWrite && stallCount != 16'hFFFF)
        stallCount <= stallCount + 16'd1;
      unique case (state)
        IDLE: begin
          if (hz.IDEXMulStart) begin
            state <= BUSY;
            cnt   <= CNT_INIT;
          end
        end
        BUSY: begin
          if (cnt != 4'd0)
            cnt <= cnt - 4'd1;
          else
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ex_hazard_scheduler.sv
// Scoreboard bench for ex_hazard_scheduler: a cycle-indexed reference model
// queues expected outputs, a monitor compares them on the falling edge.
module tb_ex_hazard_scheduler;
  localparam int MUL = 4;

  logic clock = 1'b0;
  logic resetn = 1'b0;
  always #5 clock = ~clock;

  ex_hazard_scheduler_if hz();

  ex_hazard_scheduler #(.MUL_CYCLES(MUL)) dut (
    .clock (clock),
    .resetn(resetn),
    .hz    (hz)
  );

  typedef struct packed {
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic        pc;
    logic        ifid;
    logic        idex;
    logic        flush;
    logic        bubble;
    logic        done;
    logic        busy;
    logic [15:0] stall;
  } exp_t;

  exp_t expQ[$];
  int   checks = 0;
  int   failures = 0;
  int   txn = 0;
  bit   verbose = 1'b1;
  // Model state: 0 = idle, k>0 = k-th cycle after the cycle MulStart was taken.
  int   mulAge = 0;
  int   stallModel = 0;

  function automatic logic [1:0] refFwd(input logic [4:0] src, input logic exW, input logic [4:0] exD,
                                        input logic wbW, input logic [4:0] wbD);
    if (exW && exD != 0 && exD == src) return 2'b10;
    if (wbW && wbD != 0 && wbD == src) return 2'b01;
    return 2'b00;
  endfunction

  task automatic step(input logic rstn, input logic [4:0] ifRs, input logic [4:0] ifRt,
                      input logic [4:0] exRs, input logic [4:0] exRt, input logic memRd,
                      input logic mulSt, input logic exW, input logic [4:0] exD,
                      input logic wbW, input logic [4:0] wbD);
    exp_t e;
    bit   holdNow;
    bit   ldUse;
    resetn           = rstn;
    hz.IFIDRs        = ifRs;
    hz.IFIDRt        = ifRt;
    hz.IDEXRs        = exRs;
    hz.IDEXRt        = exRt;
    hz.IDEXMemRead   = memRd;
    hz.IDEXMulStart  = mulSt;
    hz.EXMEMRegWrite = exW;
    hz.EXMEMDst      = exD;
    hz.MEMWBRegWrite = wbW;
    hz.MEMWBDst      = wbD;

    holdNow = (mulAge == 0 && mulSt) || (mulAge > 0 && mulAge < MUL - 1);
    ldUse   = !holdNow && memRd && !mulSt && exRt != 0 && (exRt == ifRs || exRt == ifRt);
    e.fa     = refFwd(exRs, exW, exD, wbW, wbD);
    e.fb     = refFwd(exRt, exW, exD, wbW, wbD);
    e.pc     = !(holdNow || ldUse);
    e.ifid   = !(holdNow || ldUse);
    e.idex   = !holdNow;
    e.flush  = ldUse;
    e.bubble = holdNow;
    e.done   = (mulAge == MUL - 1);
    e.busy   = (mulAge > 0);
    e.stall  = 16'(stallModel);
    expQ.push_back(e);

    @(posedge clock);
    if (!rstn) begin
      mulAge     = 0;
      stallModel = 0;
    end else begin
      if (!e.pc && stallModel < 65535) stallModel++;
      if (mulAge == 0) mulAge = mulSt ? 1 : 0;
      else if (mulAge == MUL - 1) mulAge = 0;
      else mulAge++;
    end
    #1;
  endtask

  task automatic idleStep();
    step(1'b1, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
  endtask

  // Monitor: the DUT presents a fresh output vector every cycle.
  initial begin
    exp_t e;
    exp_t act;
    forever begin
      @(negedge clock);
      if (expQ.size() > 0) begin
        e   = expQ.pop_front();
        act = {hz.ForwardA, hz.ForwardB, hz.PCWrite, hz.IFIDWrite, hz.IDEXWrite,
               hz.IDEXFlush, hz.EXMEMBubble, hz.MulDone, hz.Busy, hz.StallCount};
        checks++;
        txn++;
        if (act !== e) begin
          failures++;
          $display("FAIL txn%0d outputs: got fa=%b fb=%b pc=%b ifid=%b idex=%b flush=%b bub=%b done=%b busy=%b stall=%0d, want fa=%b fb=%b pc=%b ifid=%b idex=%b flush=%b bub=%b done=%b busy=%b stall=%0d",
                   txn, act.fa, act.fb, act.pc, act.ifid, act.idex, act.flush, act.bubble,
                   act.done, act.busy, act.stall, e.fa, e.fb, e.pc, e.ifid, e.idex, e.flush,
                   e.bubble, e.done, e.busy, e.stall);
        end else if (verbose) begin
          $display("txn%0d ok fa=%b fb=%b pc=%b flush=%b bub=%b done=%b busy=%b stall=%0d",
                   txn, act.fa, act.fb, act.pc, act.flush, act.bubble, act.done, act.busy, act.stall);
        end
      end
    end
  end

  initial begin
    resetn           = 1'b0;
    hz.IFIDRs        = 5'd0;
    hz.IFIDRt        = 5'd0;
    hz.IDEXRs        = 5'd0;
    hz.IDEXRt        = 5'd0;
    hz.IDEXMemRead   = 1'b0;
    hz.IDEXMulStart  = 1'b0;
    hz.EXMEMRegWrite = 1'b0;
    hz.EXMEMDst      = 5'd0;
    hz.MEMWBRegWrite = 1'b0;
    hz.MEMWBDst      = 5'd0;
    repeat (2) @(posedge clock);
    #1;

    // Post-reset idle outputs.
    idleStep();

    // Forwarding priority: MEM over WB, zero destination never forwards.
    step(1'b1, 5'd0, 5'd0, 5'd4, 5'd0, 1'b0, 1'b0, 1'b1, 5'd4, 1'b1, 5'd4);
    step(1'b1, 5'd0, 5'd0, 5'd4, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b1, 5'd4);
    step(1'b1, 5'd0, 5'd0, 5'd4, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 5'd4);
    step(1'b1, 5'd0, 5'd0, 5'd1, 5'd4, 1'b0, 1'b0, 1'b1, 5'd4, 1'b1, 5'd4);

    // Single load-use stall.
    step(1'b1, 5'd0, 5'd8, 5'd0, 5'd8, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
    idleStep();

    // Multi-cycle op with MulStart held, restarting from IDLE.
    repeat (6) step(1'b1, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0);
    repeat (3) idleStep();

    // Multi-cycle op overlapping a load-use match.
    repeat (4) step(1'b1, 5'd8, 5'd0, 5'd0, 5'd8, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0);
    idleStep();

    // Reset in the middle of an op.
    step(1'b1, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0);
    idleStep();
    step(1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0);
    repeat (3) idleStep();

    // Randomized traffic with small register numbers to provoke matches.
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 39) != 0),
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0),
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)));
    end

    // Saturation of the stall counter.
    verbose = 1'b0;
    step(1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
    for (int i = 0; i < 70000; i++)
      step(1'b1, 5'd3, 5'd0, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
    verbose = 1'b1;
    repeat (2) idleStep();

    @(negedge clock);
    #1;
    checks++;
    if (expQ.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending, want 0", expQ.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
